tx_packet_arbiter: RTL

Packet-atomic round-robin arbiter that shares the single UART transmit byte channel among N_IN framed byte-stream producers (command encoder, status/heartbeat generator, etc.). Sits between the producers' tx_data/tx_valid/tx_ready interfaces and the UART transmitter. It tracks each frame's length from its header byte, so a frame is never interleaved with another. It also drops frames with a bad prefix and releases the channel if a producer stalls mid-frame.

---
 rtl/tx_packet_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/tx_packet_arbiter.sv
// tx_packet_arbiter: packet-atomic round-robin arbiter that shares one UART
// transmit byte channel among N_IN framed byte-stream producers. Each frame's
// length comes from its header, so frames are never interleaved. Frames with a
// bad prefix byte are dropped, and a stalled producer loses the channel.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   in_valid    per-producer byte valid
//   in_data     per-producer byte, input i at [8*i+:8]
//   in_ready    per-producer byte accept (only the granted input can be high)
//   out_data    byte to UART (combinational mux of the granted input)
//   out_valid   byte valid to UART
//   out_ready   UART ready
//   grant       one-hot current owner, 0 when idle
//   busy        frame in progress
//   timeout_err one-cycle pulse when a stalled frame is aborted
//   drop_cnt    saturating count of frames dropped for a bad prefix
module tx_packet_arbiter #(
    parameter int unsigned N_IN    = 2,
    parameter logic [7:0]  PREFIX  = 8'hAA,
    parameter int unsigned LEN_POS = 3,
    parameter int unsigned HDR_LEN = 4,
    parameter int unsigned TRL_LEN = 1,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IN-1:0]   in_valid,
    input  logic [8*N_IN-1:0] in_data,
    output logic [N_IN-1:0]   in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_IN-1:0]   grant,
    output logic              busy,
    output logic              timeout_err,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned SW = $clog2(TIMEOUT + 1);
    // Frame end index is TAIL + len.
    localparam logic [8:0]  TAIL     = 9'(HDR_LEN + TRL_LEN - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);

    typedef enum logic {
        IDLE,
        PASS
    } state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   last_grant, last_grant_nx;
    logic [IW-1:0]   owner, owner_nx;
    logic [N_IN-1:0] grant_nx;
    logic            busy_nx;
    logic            timeout_nx;
    logic [7:0]      drop_cnt_nx;
    logic [7:0]      len, len_nx;
    logic [8:0]      byte_cnt, byte_cnt_nx;
    logic [SW-1:0]   stall_cnt, stall_cnt_nx;

    logic            cur_valid;
    logic [7:0]      cur_data;
    logic            pick_found;
    logic [IW-1:0]   pick;

    // Index base+k reduced modulo N_IN (k never exceeds N_IN).
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= N_IN) s = s - N_IN;
        return IW'(s);
    endfunction

    // Round-robin pick: first requester after last_grant, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        for (int unsigned k = 1; k <= N_IN; k++) begin
            if (!pick_found && in_valid[wrap_idx(last_grant, k)]) begin
                pick_found = 1'b1;
                pick       = wrap_idx(last_grant, k);
            end
        end
    end

    // Datapath mux selected by the one-hot grant register.
    always_comb begin
        cur_valid = 1'b0;
        cur_data  = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (grant[i]) begin
                cur_valid = in_valid[i];
                cur_data  = in_data[8*i +: 8];
            end
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= LAST_IDX;
            owner       <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            drop_cnt    <= '0;
            len         <= '0;
            byte_cnt    <= '0;
            stall_cnt   <= '0;
        end else begin
            state       <= state_nx;
            last_grant  <= last_grant_nx;
            owner       <= owner_nx;
            grant       <= grant_nx;
            busy        <= busy_nx;
            timeout_err <= timeout_nx;
            drop_cnt    <= drop_cnt_nx;
            len         <= len_nx;
            byte_cnt    <= byte_cnt_nx;
            stall_cnt   <= stall_cnt_nx;
        end
    end

    // Next-state, handshake and frame tracking.
    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        owner_nx      = owner;
        grant_nx      = grant;
        busy_nx       = busy;
        timeout_nx    = 1'b0;
        drop_cnt_nx   = drop_cnt;
        len_nx        = len;
        byte_cnt_nx   = byte_cnt;
        stall_cnt_nx  = stall_cnt;
        in_ready      = '0;
        out_valid     = 1'b0;
        out_data      = cur_data;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_nx     = pick;
                    grant_nx     = N_IN'(1) << pick;
                    busy_nx      = 1'b1;
                    byte_cnt_nx  = '0;
                    stall_cnt_nx = '0;
                    state_nx     = PASS;
                end
            end

            PASS: begin
                if (byte_cnt == 9'd0 && cur_valid && cur_data != PREFIX) begin
                    // Bad prefix: swallow the byte without forwarding it.
                    in_ready = grant;
                    if (drop_cnt != 8'hFF) drop_cnt_nx = drop_cnt + 8'd1;
                    last_grant_nx = owner;
                    grant_nx      = '0;
                    busy_nx       = 1'b0;
                    state_nx      = IDLE;
                end else begin
                    out_valid = cur_valid;
                    in_ready  = grant & {N_IN{out_ready}};
                    if (cur_valid && out_ready) begin
                        byte_cnt_nx  = byte_cnt + 9'd1;
                        stall_cnt_nx = '0;
                        if (byte_cnt == 9'(LEN_POS)) len_nx = cur_data;
                        // len is only valid once the length byte has passed.
                        if (byte_cnt > 9'(LEN_POS) && byte_cnt == TAIL + 9'(len)) begin
                            last_grant_nx = owner;
                            grant_nx      = '0;
                            busy_nx       = 1'b0;
                            state_nx      = IDLE;
                        end
                    end else if (!cur_valid) begin
                        // Producer stall; downstream backpressure holds the count.
                        if (stall_cnt == SW'(TIMEOUT - 1)) begin
                            timeout_nx    = 1'b1;
                            last_grant_nx = owner;
                            grant_nx      = '0;
                            busy_nx       = 1'b0;
                            state_nx      = IDLE;
                        end else begin
                            stall_cnt_nx = stall_cnt + SW'(1);
                        end
                    end
                end
            end

            default: state_nx = IDLE;
        endcase

        // Nothing moves during reset, even from a mid-frame state.
        if (rst) begin
            in_ready  = '0;
            out_valid = 1'b0;
        end
    end

endmodule
